retire_trace_buffer: RTL

- Synthesizable retirement-trace capture unit for the pipelined RV64 core; replaces bench-side per-cycle printing with an in-design trace.
- Sits beside the writeback stage and records every retired instruction (PC, instruction, rd, write data) into a parametrised buffer.
- Detects the all-zero halt instruction, maintains cycle/instret counters and drains through a valid/ready read port to a bench or debug host.

---
 rtl/trace_pkg.sv | 21 ++
 rtl/trace_fifo.sv | 51 +++++
 rtl/retire_trace_buffer.sv | 95 +++++++++
 3 files changed

// File: rtl/trace_pkg.sv
// Shared types and constants for the retirement trace buffer.
// Build with TRACE_TIMESTAMP_EN defined to add a per-entry push timestamp.
package trace_pkg;
  localparam logic [31:0] HALT_INSTR = 32'h0000_0000;
  localparam int MODE_DROP   = 0;
  localparam int MODE_WRAP   = 1;
  localparam int TRACE_XLEN  = 64;
  localparam int TRACE_CNT_W = 64;

  // Fields sized for the widest supported core; narrower XLEN zero-extends.
  typedef struct packed {
    logic [TRACE_XLEN-1:0]  pc;
    logic [31:0]            instr;
    logic [4:0]             rd;
    logic                   we;
    logic [TRACE_XLEN-1:0]  wdata;
`ifdef TRACE_TIMESTAMP_EN
    logic [TRACE_CNT_W-1:0] timestamp;
`endif
  } trace_entry_t;
endpackage

// File: rtl/trace_fifo.sv
// Trace storage: circular buffer with separate level count and a drop or
// overwrite-oldest policy when a push meets a full buffer with no pop.
module trace_fifo import trace_pkg::*; #(
  parameter int DEPTH     = 16,
  parameter int W         = 8,
  parameter int WRAP_MODE = MODE_DROP,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          ready,
  output logic          valid,
  output logic [W-1:0]  dout,
  output logic [AW:0]   level,
  output logic          lost
);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          full, pop, wr_en, wrap_ovr;

  always_comb begin
    full     = (level == (AW+1)'(DEPTH));
    valid    = (level != '0);
    pop      = valid & ready;
    lost     = push & full & ~pop;
    wrap_ovr = lost & (WRAP_MODE == MODE_WRAP);
    wr_en    = push & (~lost | wrap_ovr);
  end

  // Head is presented combinationally; an empty buffer shows all-zero fields.
  assign dout = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk)
    if (wr_en) mem[wr_ptr] <= din;

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      // An overwrite while full consumes the oldest slot, so the head moves too.
      if (pop || wrap_ovr) rd_ptr <= rd_ptr + AW'(1);
      if (push && !full && !pop)  level <= level + (AW+1)'(1);
      else if (pop && !push)      level <= level - (AW+1)'(1);
    end
  end
endmodule

// File: rtl/retire_trace_buffer.sv
// Retirement trace capture beside writeback: halt detection, counters and
// the trace FIFO drained through a valid/ready port. Optional TRACE_TIMESTAMP_EN.
module retire_trace_buffer import trace_pkg::*; #(
  parameter int XLEN      = 64,
  parameter int DEPTH     = 16,
  parameter int WRAP_MODE = 0,
  parameter int CNT_W     = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     capture_en,
  input  logic                     retire_valid,
  input  logic [XLEN-1:0]          retire_pc,
  input  logic [31:0]              retire_instr,
  input  logic [4:0]               retire_rd,
  input  logic                     retire_we,
  input  logic [XLEN-1:0]          retire_wdata,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_pc,
  output logic [31:0]              out_instr,
  output logic [4:0]               out_rd,
  output logic                     out_we,
  output logic [XLEN-1:0]          out_wdata,
`ifdef TRACE_TIMESTAMP_EN
  output logic [CNT_W-1:0]         out_timestamp,
`endif
  output logic [$clog2(DEPTH):0]   level,
  output logic                     halted,
  output logic                     overflow,
  output logic [CNT_W-1:0]         cycle_count,
  output logic [CNT_W-1:0]         instret_count,
  output logic [CNT_W-1:0]         drop_count
);
  trace_entry_t din, head;
  logic         push, lost;

  assign push = retire_valid & capture_en & ~halted;

  always_comb begin
    din       = '0;
    din.pc    = TRACE_XLEN'(retire_pc);
    din.instr = retire_instr;
    din.rd    = retire_rd;
    din.we    = retire_we;
    din.wdata = TRACE_XLEN'(retire_wdata);
`ifdef TRACE_TIMESTAMP_EN
    din.timestamp = TRACE_CNT_W'(cycle_count);
`endif
  end

  trace_fifo #(
    .DEPTH     (DEPTH),
    .W         ($bits(trace_entry_t)),
    .WRAP_MODE (WRAP_MODE)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (din),
    .ready (out_ready),
    .valid (out_valid),
    .dout  (head),
    .level (level),
    .lost  (lost)
  );

  assign out_pc    = head.pc[XLEN-1:0];
  assign out_instr = head.instr;
  assign out_rd    = head.rd;
  assign out_we    = head.we;
  assign out_wdata = head.wdata[XLEN-1:0];
`ifdef TRACE_TIMESTAMP_EN
  assign out_timestamp = CNT_W'(head.timestamp);
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      halted        <= 1'b0;
      overflow      <= 1'b0;
      cycle_count   <= '0;
      instret_count <= '0;
      drop_count    <= '0;
    end else begin
      // The halt instruction is still recorded; it only gates later retires.
      if (push && retire_instr == HALT_INSTR) halted <= 1'b1;
      if (lost) begin
        overflow   <= 1'b1;
        drop_count <= drop_count + CNT_W'(1);
      end
      if (!halted) cycle_count <= cycle_count + CNT_W'(1);
      if (retire_valid && !halted) instret_count <= instret_count + CNT_W'(1);
    end
  end
endmodule
